// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the OAM DMA engine and its surroundings: the CPU-side
// trigger, the data-memory read port and the OAM write port.
//
// Handshake semantics: start is a single-cycle request. It is accepted only
// when busy is low, and src_addr is sampled in that same cycle. busy rises on
// the following cycle and stays high until done has pulsed. mem_rd_data must
// be valid exactly one cycle after mem_rd_en is high. The OAM side is a
// write-only port with no back-pressure: oam_wr_en high means oam_addr and
// oam_wr_data are written in that cycle.
interface oam_dma_ctrl_if #(
  parameter int DATA_AW = 12,
  parameter int DATA_W  = 32,
  parameter int OAM_AW  = 8
);
  logic               start;
  logic [DATA_AW-1:0] src_addr;
  logic               busy;
  logic               mem_rd_en;
  logic [DATA_AW-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_rd_data;
  logic               oam_wr_en;
  logic [OAM_AW-1:0]  oam_addr;
  logic [DATA_W-1:0]  oam_wr_data;
  logic               done;

  // DMA engine side
  modport master (
    input  start, src_addr, mem_rd_data,
    output busy, mem_rd_en, mem_addr, oam_wr_en, oam_addr, oam_wr_data, done
  );

  // CPU / memory / OAM side
  modport slave (
    output start, src_addr, mem_rd_data,
    input  busy, mem_rd_en, mem_addr, oam_wr_en, oam_addr, oam_wr_data, done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-attribute DMA: copies XFER_LEN words from data memory into OAM.
// Reads are issued back to back; each read's data is written to OAM the
// following cycle, straight from the memory's read-data bus.
module oam_dma_ctrl #(
  parameter int DATA_AW  = 12,
  parameter int DATA_W   = 32,
  parameter int OAM_AW   = 8,
  parameter int XFER_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  oam_dma_ctrl_if.master bus,
  output logic [1:0]  dbg_state
);

  // The read index must be able to hold XFER_LEN itself (e.g. 256).
  localparam int IDX_W = OAM_AW + 1;
  localparam logic [IDX_W-1:0] LEN = IDX_W'(XFER_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_AW-1:0] base_q, base_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [OAM_AW-1:0]  wr_idx_q, wr_idx_d;
  logic               busy_q, busy_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [DATA_AW-1:0] mem_addr_q, mem_addr_d;
  logic               oam_wr_en_q, oam_wr_en_d;
  logic [OAM_AW-1:0]  oam_addr_q, oam_addr_d;
  logic               done_q, done_d;

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      busy_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      oam_wr_en_q <= 1'b0;
      oam_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      busy_q      <= busy_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      oam_wr_en_q <= oam_wr_en_d;
      oam_addr_q  <= oam_addr_d;
      done_q      <= done_d;
    end
  end

  // Next-state, read sequencing and the one-cycle-delayed write pipeline.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    oam_wr_en_d = 1'b0;
    oam_addr_d  = oam_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // First read goes out directly at the base address.
          base_d      = bus.src_addr;
          mem_addr_d  = bus.src_addr;
          rd_idx_d    = IDX_W'(1);
          wr_idx_d    = '0;
          mem_rd_en_d = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        if (rd_idx_q == LEN) begin
          state_d = DRAIN;
        end else begin
          // Address arithmetic wraps at the top of data memory.
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + DATA_AW'(rd_idx_q);
          rd_idx_d    = rd_idx_q + IDX_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every read issued last cycle becomes an OAM write this cycle.
    if (mem_rd_en_q) begin
      oam_wr_en_d = 1'b1;
      oam_addr_d  = wr_idx_q;
      wr_idx_d    = wr_idx_q + OAM_AW'(1);
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.oam_wr_en   = oam_wr_en_q;
  assign bus.oam_addr    = oam_addr_q;
  assign bus.oam_wr_data = bus.mem_rd_data;
  assign bus.done        = done_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a 4-word instance for the main cases and
// a 1-word instance for the single-word and back-to-back cases.
module tb_oam_dma_ctrl;

  logic clk;
  logic rst;
  logic [1:0] dbg4, dbg1;
  logic [31:0] mem [0:4095];
  logic [31:0] rd4, rd1;
  int n_tests = 0;
  int n_fail  = 0;

  oam_dma_ctrl_if #(.DATA_AW(12), .DATA_W(32), .OAM_AW(8)) bus4();
  oam_dma_ctrl_if #(.DATA_AW(12), .DATA_W(32), .OAM_AW(8)) bus1();

  oam_dma_ctrl #(.DATA_AW(12), .DATA_W(32), .OAM_AW(8), .XFER_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg4)
  );
  oam_dma_ctrl #(.DATA_AW(12), .DATA_W(32), .OAM_AW(8), .XFER_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one-cycle-latency data memories
  always @(posedge clk) if (bus4.mem_rd_en) rd4 <= mem[bus4.mem_addr];
  always @(posedge clk) if (bus1.mem_rd_en) rd1 <= mem[bus1.mem_addr];
  assign bus4.mem_rd_data = rd4;
  assign bus1.mem_rd_data = rd1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Runs one XFER_LEN=4 transfer from a negedge with the DUT idle, checking
  // cycles 1..7. If restart_at is in 1..7 a second start (src 0x200) is
  // pulsed in that cycle.
  task automatic xfer4(input logic [11:0] src, input logic [3:0][31:0] exp_d,
                       input int restart_at, input string nm);
    logic [11:0] ea;
    logic [31:0] eo;
    logic [31:0] es;
    bus4.src_addr = src;
    bus4.start    = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      ea = src + 12'((k <= 4) ? k - 1 : 3);
      eo = (k <= 5) ? 32'(k - 2) : 32'd3;
      es = (k <= 4) ? 32'd1 : (k == 5) ? 32'd2 : (k == 6) ? 32'd3 : 32'd0;
      chk($sformatf("%s c%0d busy", nm, k), 32'(bus4.busy), 32'(k <= 6));
      chk($sformatf("%s c%0d rd_en", nm, k), 32'(bus4.mem_rd_en), 32'(k <= 4));
      chk($sformatf("%s c%0d mem_addr", nm, k), 32'(bus4.mem_addr), 32'(ea));
      chk($sformatf("%s c%0d wr_en", nm, k), 32'(bus4.oam_wr_en), 32'(k >= 2 && k <= 5));
      chk($sformatf("%s c%0d done", nm, k), 32'(bus4.done), 32'(k == 6));
      chk($sformatf("%s c%0d state", nm, k), 32'(dbg4), es);
      if (k >= 2) chk($sformatf("%s c%0d oam_addr", nm, k), 32'(bus4.oam_addr), eo);
      if (k >= 2 && k <= 5)
        chk($sformatf("%s c%0d wr_data", nm, k), bus4.oam_wr_data, exp_d[k-2]);
      if (k == restart_at) begin
        bus4.start    = 1'b1;
        bus4.src_addr = 12'h200;
      end else begin
        bus4.start = 1'b0;
      end
      @(negedge clk);
    end
    bus4.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus4.start = 1'b0; bus4.src_addr = '0;
    bus1.start = 1'b0; bus1.src_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = {20'h5A5A5, 12'(i)};
    mem[12'h100] = 32'hA0; mem[12'h101] = 32'hA1;
    mem[12'h102] = 32'hA2; mem[12'h103] = 32'hA3;

    // reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(bus4.busy), 32'd0);
    chk("rst rd_en", 32'(bus4.mem_rd_en), 32'd0);
    chk("rst wr_en", 32'(bus4.oam_wr_en), 32'd0);
    chk("rst done", 32'(bus4.done), 32'd0);
    chk("rst mem_addr", 32'(bus4.mem_addr), 32'd0);
    chk("rst oam_addr", 32'(bus4.oam_addr), 32'd0);
    chk("rst state", 32'(dbg4), 32'd0);
    chk("rst1 busy", 32'(bus1.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", 32'(bus4.busy), 32'd0);

    xfer4(12'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, "basic");
    xfer4(12'hFFE, {32'h5A5A5001, 32'h5A5A5000, 32'h5A5A5FFF, 32'h5A5A5FFE}, 0, "wrap");
    xfer4(12'h300, {32'h5A5A5303, 32'h5A5A5302, 32'h5A5A5301, 32'h5A5A5300}, 3, "restart");

    // reset mid-transfer
    bus4.src_addr = 12'h010;
    bus4.start    = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort c3 busy", 32'(bus4.busy), 32'd1);
    chk("abort c3 wr_en", 32'(bus4.oam_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(bus4.busy), 32'd0);
    chk("abort rd_en", 32'(bus4.mem_rd_en), 32'd0);
    chk("abort wr_en", 32'(bus4.oam_wr_en), 32'd0);
    chk("abort state", 32'(dbg4), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort quiet%0d done", k), 32'(bus4.done), 32'd0);
      chk($sformatf("abort quiet%0d wr_en", k), 32'(bus4.oam_wr_en), 32'd0);
    end
    xfer4(12'h000, {32'h5A5A5003, 32'h5A5A5002, 32'h5A5A5001, 32'h5A5A5000}, 0, "fresh");

    // XFER_LEN=1: start-with-done ignored, then back-to-back start
    bus1.src_addr = 12'h030;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("len1 c1 rd_en", 32'(bus1.mem_rd_en), 32'd1);
    chk("len1 c1 mem_addr", 32'(bus1.mem_addr), 32'h030);
    chk("len1 c1 wr_en", 32'(bus1.oam_wr_en), 32'd0);
    chk("len1 c1 busy", 32'(bus1.busy), 32'd1);
    @(negedge clk);
    chk("len1 c2 rd_en", 32'(bus1.mem_rd_en), 32'd0);
    chk("len1 c2 wr_en", 32'(bus1.oam_wr_en), 32'd1);
    chk("len1 c2 oam_addr", 32'(bus1.oam_addr), 32'd0);
    chk("len1 c2 wr_data", bus1.oam_wr_data, 32'h5A5A5030);
    chk("len1 c2 state", 32'(dbg1), 32'd2);
    chk("len1 c2 done", 32'(bus1.done), 32'd0);
    @(negedge clk);
    chk("len1 c3 done", 32'(bus1.done), 32'd1);
    chk("len1 c3 wr_en", 32'(bus1.oam_wr_en), 32'd0);
    chk("len1 c3 busy", 32'(bus1.busy), 32'd1);
    bus1.src_addr = 12'h050;
    bus1.start    = 1'b1;
    @(negedge clk);
    chk("len1 c4 busy", 32'(bus1.busy), 32'd0);
    chk("len1 c4 rd_en", 32'(bus1.mem_rd_en), 32'd0);
    chk("len1 c4 done", 32'(bus1.done), 32'd0);
    bus1.src_addr = 12'h040;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("b2b c1 rd_en", 32'(bus1.mem_rd_en), 32'd1);
    chk("b2b c1 mem_addr", 32'(bus1.mem_addr), 32'h040);
    @(negedge clk);
    chk("b2b c2 wr_en", 32'(bus1.oam_wr_en), 32'd1);
    chk("b2b c2 oam_addr", 32'(bus1.oam_addr), 32'd0);
    chk("b2b c2 wr_data", bus1.oam_wr_data, 32'h5A5A5040);
    @(negedge clk);
    chk("b2b c3 done", 32'(bus1.done), 32'd1);
    @(negedge clk);
    chk("b2b c4 busy", 32'(bus1.busy), 32'd0);
    chk("b2b c4 done", 32'(bus1.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite-attribute DMA engine that sits directly downstream of the CPU's MEM stage.
- Triggered by a single-cycle start pulse, produced when the CPU stores to the DMA trigger address.
- Copies XFER_LEN consecutive 32-bit words from data memory into OAM.
- Holds the CPU pipeline stalled for the whole transfer and owns the data-memory read port while busy.

Parameters:
- DATA_AW, 12, data-memory word address width (matches the memory controller's data_addr).
- DATA_W, 32, data word width.
- OAM_AW, 8, OAM word address width.
- XFER_LEN, 256, words per transfer; legal range 1..2**OAM_AW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle trigger from the MEM stage's DMA register store.
- src_addr  input  DATA_AW  base data-memory word address; sampled only when start is accepted.
- busy  output  1  transfer in progress; the top level ORs this into the pipeline stall.
- mem_rd_en  output  1  data-memory read request; when high, the memory controller muxes it over the CPU's port.
- mem_addr  output  DATA_AW  data-memory read address.
- mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en (one-cycle latency).
- oam_wr_en  output  1  OAM write strobe.
- oam_addr  output  OAM_AW  OAM write address.
- oam_wr_data  output  DATA_W  OAM write data.
- done  output  1  one-cycle pulse when the last word has been written.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE. busy, mem_rd_en, oam_wr_en and done are 0. mem_addr=0, oam_addr=0. Read and OAM index counters are cleared.
- Reset mid-transfer aborts immediately: no further reads or writes; OAM is left partially written.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches src_addr into the base register, clears the read index, and moves to READ.
  - start=0: no change.
- READ:
  - Every cycle: mem_rd_en=1, mem_addr=(base+rd_idx) mod 2**DATA_AW (wraps past the top of memory), then rd_idx increments.
  - When rd_idx==XFER_LEN-1 is issued, move to DRAIN.
  - Reads are issued back to back with no bubbles.
- Write pipeline (registered):
  - One cycle after each read, oam_wr_en=1 and oam_addr=wr_idx, starting at 0 and incrementing by 1.
  - oam_wr_data=mem_rd_data, passed through combinationally in that cycle.
  - Because of this, OAM writes occur in READ cycles 2..N and in the DRAIN cycle.
- DRAIN: mem_rd_en=0; performs the final OAM write (oam_addr=XFER_LEN-1); then moves to DONE.
- DONE: done=1 for exactly one cycle, oam_wr_en=0, then moves to IDLE.
- busy=1 in READ, DRAIN and DONE; 0 in IDLE.
- All outputs are registered except oam_wr_data.
- Timing: start sampled at edge 0 → busy and first mem_rd_en at cycle 1 → first OAM write at cycle 2 → last OAM write at cycle XFER_LEN+1 → done at cycle XFER_LEN+2 → busy low at cycle XFER_LEN+3.
- start while busy: ignored; no restart and no re-latch of src_addr.
- start asserted in the same cycle as done: ignored. A new start is accepted only from IDLE.
- XFER_LEN=1: READ lasts one cycle, then DRAIN, then DONE.
- oam_addr never wraps within a transfer, because XFER_LEN≤2**OAM_AW.
- mem_addr and oam_addr hold their last value when their strobes are low.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 → busy, mem_rd_en, oam_wr_en and done all 0; mem_addr=0.
- Basic transfer: XFER_LEN=4, memory[0x100..0x103]=A0,A1,A2,A3, start pulse with src_addr=0x100.
  - mem_rd_en high cycles 1–4 with addresses 0x100..0x103.
  - oam writes at cycles 2–5: addr 0..3, data A0..A3.
  - done at cycle 6; busy high cycles 1–6.
- Address wrap: src_addr=0xFFE, XFER_LEN=4 → mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; oam_addr 0..3.
- Start while busy: second start at cycle 3 with src_addr=0x200 → ignored; reads continue from the original base, and exactly one done pulse occurs.
- Reset mid-transfer: rst at cycle 3 of an XFER_LEN=256 transfer → next cycle busy, mem_rd_en and oam_wr_en are 0; no done pulse. A fresh start with src_addr=0x000 then completes normally from oam_addr 0.
- Back-to-back transfers: start again the cycle after busy falls with src_addr=0x040, XFER_LEN=1 → one read at 0x040 at cycle 1, an OAM write to addr 0 at cycle 2, done at cycle 3.
